// File: rtl/shifter_seq_n_pkg.sv
// Shared op codes, FSM states and mux selects for the sequential shifter.
// Imported by the interface, the one-step unit and the top level.
package shifter_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_LSL  = 3'b010;
    localparam logic [2:0] OP_LSR  = 3'b011;
    localparam logic [2:0] OP_ASR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ROR  = 3'b110;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SEL_HOLD  = 2'd0,
        SEL_LEFT  = 2'd1,
        SEL_RIGHT = 2'd2,
        SEL_FILL  = 2'd3
    } sel_e;

    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == OP_LSL) || (op == OP_LSR) || (op == OP_ASR) ||
               (op == OP_ROL) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/shifter_seq_n_if.sv
// Request/response bundle of the sequential shifter.
// master drives requests, slave is the shifter itself.
interface shifter_seq_n_if #(
    parameter int WIDTH = 8
);
    localparam int AW = $clog2(WIDTH);

    logic             start;
    logic [2:0]       op;
    logic [AW-1:0]    amt;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] q;
    logic             shift_out;
    logic             busy;
    logic             done;

    modport master (
        output start, op, amt, d_in,
        input  q, shift_out, busy, done
    );

    modport slave (
        input  start, op, amt, d_in,
        output q, shift_out, busy, done
    );

endinterface

// File: rtl/shifter_seq_n_shift1_unit.sv
// One-position shift/rotate step built from per-bit 4:1 selects.
// Rotates and ASR reuse the fill leg with a data-dependent fill bit.
module shift1_unit
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] q_next,
    output logic             bit_out
);

    logic go_left;
    logic go_right;
    logic fill;

    always_comb begin
        go_left  = 1'b0;
        go_right = 1'b0;
        fill     = 1'b0;
        bit_out  = 1'b0;
        unique case (1'b1)
            (op == OP_LSL): begin
                go_left = 1'b1;
                bit_out = q[WIDTH-1];
            end
            (op == OP_ROL): begin
                go_left = 1'b1;
                fill    = q[WIDTH-1];
                bit_out = q[WIDTH-1];
            end
            (op == OP_LSR): begin
                go_right = 1'b1;
                bit_out  = q[0];
            end
            (op == OP_ASR): begin
                go_right = 1'b1;
                fill     = q[WIDTH-1];
                bit_out  = q[0];
            end
            (op == OP_ROR): begin
                go_right = 1'b1;
                fill     = q[0];
                bit_out  = q[0];
            end
            default: begin
            end
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        // Wrapped neighbour indices keep the edge bits in range; the
        // edge bits never select them because they take the fill leg.
        localparam int LI = (i + WIDTH - 1) % WIDTH;
        localparam int RI = (i + 1) % WIDTH;

        sel_e sel;
        logic b;

        always_comb begin
            sel = SEL_HOLD;
            if (go_left) begin
                sel = (i == 0) ? SEL_FILL : SEL_LEFT;
            end else if (go_right) begin
                sel = (i == WIDTH - 1) ? SEL_FILL : SEL_RIGHT;
            end
        end

        always_comb begin
            b = q[i];
            unique case (sel)
                SEL_HOLD:  b = q[i];
                SEL_LEFT:  b = q[LI];
                SEL_RIGHT: b = q[RI];
                SEL_FILL:  b = fill;
                default:   b = q[i];
            endcase
        end

        assign q_next[i] = b;
    end

endmodule

// File: rtl/shifter_seq_n.sv
// Multi-cycle shifter: one bit position per clock, start/busy/done.
// Holds the FSM, step counter, latched op and the output registers.
module shifter_seq_n
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    shifter_seq_n_if.slave  bus
);

    localparam int AW = $clog2(WIDTH);

    state_e           state;
    logic [AW-1:0]    cnt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] q_r;
    logic             so_r;
    logic             busy_r;
    logic             done_r;

    logic [2:0]       op_sel;
    logic [WIDTH-1:0] q_step;
    logic             bit_step;

    // In IDLE the first step uses the live op; afterwards the latched one.
    assign op_sel = (state == ST_IDLE) ? bus.op : op_q;

    shift1_unit #(
        .WIDTH (WIDTH)
    ) u_step (
        .q       (q_r),
        .op      (op_sel),
        .q_next  (q_step),
        .bit_out (bit_step)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            op_q   <= OP_NOP;
            q_r    <= '0;
            so_r   <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (is_shift_op(bus.op) && (bus.amt != '0)) begin
                            op_q <= bus.op;
                            q_r  <= q_step;
                            so_r <= bit_step;
                            cnt  <= bus.amt - AW'(1);
                            if (bus.amt == AW'(1)) begin
                                done_r <= 1'b1;
                            end else begin
                                state  <= ST_SHIFT;
                                busy_r <= 1'b1;
                            end
                        end else begin
                            if (bus.op == OP_LOAD) begin
                                q_r <= bus.d_in;
                            end
                            done_r <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    q_r  <= q_step;
                    so_r <= bit_step;
                    cnt  <= cnt - AW'(1);
                    if (cnt == AW'(1)) begin
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.q         = q_r;
    assign bus.shift_out = so_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;

endmodule

// File: tb/tb_shifter_seq_n.sv
// Directed bench for shifter_seq_n at WIDTH=8 and WIDTH=16.
// Inputs driven and outputs sampled on the falling edge.
module tb_shifter_seq_n;
    import shifter_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   n_done8;
    int   lat;
    int   bz;
    int   n0;

    shifter_seq_n_if #(.WIDTH(8))  if8 ();
    shifter_seq_n_if #(.WIDTH(16)) if16 ();

    shifter_seq_n #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (if8)
    );

    shifter_seq_n #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (if16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (if8.done) n_done8++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic go8(input logic [2:0] op, input logic [2:0] amt,
                       input logic [7:0] d);
        if8.start = 1'b1;
        if8.op    = op;
        if8.amt   = amt;
        if8.d_in  = d;
        @(negedge clk);
        if8.start = 1'b0;
    endtask

    task automatic go16(input logic [2:0] op, input logic [3:0] amt,
                        input logic [15:0] d);
        if16.start = 1'b1;
        if16.op    = op;
        if16.amt   = amt;
        if16.d_in  = d;
        @(negedge clk);
        if16.start = 1'b0;
    endtask

    task automatic wait8(output int l, output int b);
        l = 1;
        b = 0;
        while (!if8.done && l < 40) begin
            if (if8.busy) b++;
            @(negedge clk);
            l++;
        end
    endtask

    task automatic wait16(output int l, output int b);
        l = 1;
        b = 0;
        while (!if16.done && l < 40) begin
            if (if16.busy) b++;
            @(negedge clk);
            l++;
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        n_done8 = 0;
        reset   = 1'b1;
        if8.start = 1'b0; if8.op = OP_NOP; if8.amt = '0; if8.d_in = '0;
        if16.start = 1'b0; if16.op = OP_NOP; if16.amt = '0; if16.d_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_q", 32'(if8.q), 32'h00);
        check("rst_so", 32'(if8.shift_out), 32'h0);
        check("rst_busy", 32'(if8.busy), 32'h0);
        check("rst_done", 32'(if8.done), 32'h0);

        go8(OP_LOAD, 3'd0, 8'hB5);
        check("load_q", 32'(if8.q), 32'hB5);
        check("load_done", 32'(if8.done), 32'h1);
        check("load_busy", 32'(if8.busy), 32'h0);
        @(negedge clk);
        check("load_done_fall", 32'(if8.done), 32'h0);

        go8(OP_ROL, 3'd3, 8'h00);
        wait8(lat, bz);
        check("rol3_lat", 32'(lat), 32'd3);
        check("rol3_busy", 32'(bz), 32'd2);
        check("rol3_q", 32'(if8.q), 32'hAD);
        check("rol3_so", 32'(if8.shift_out), 32'h1);

        go8(OP_LOAD, 3'd0, 8'hB5);
        check("load_keeps_so", 32'(if8.shift_out), 32'h1);
        go8(OP_ASR, 3'd2, 8'h00);
        wait8(lat, bz);
        check("asr2_lat", 32'(lat), 32'd2);
        check("asr2_q", 32'(if8.q), 32'hED);
        check("asr2_so", 32'(if8.shift_out), 32'h0);

        go8(OP_LOAD, 3'd0, 8'hB5);
        go8(OP_LSL, 3'd1, 8'h00);
        check("lsl1_done", 32'(if8.done), 32'h1);
        check("lsl1_busy", 32'(if8.busy), 32'h0);
        check("lsl1_q", 32'(if8.q), 32'h6A);
        check("lsl1_so", 32'(if8.shift_out), 32'h1);

        go8(OP_LOAD, 3'd0, 8'h96);
        n0 = n_done8;
        go8(OP_LSR, 3'd7, 8'h00);
        check("lsr7_busy", 32'(if8.busy), 32'h1);
        go8(OP_LOAD, 3'd0, 8'hFF);
        wait8(lat, bz);
        check("lsr7_lat", 32'(lat), 32'd6);
        check("lsr7_q", 32'(if8.q), 32'h01);
        check("lsr7_so", 32'(if8.shift_out), 32'h0);
        repeat (3) @(negedge clk);
        check("lsr7_one_done", 32'(n_done8 - n0), 32'd1);
        check("lsr7_q_kept", 32'(if8.q), 32'h01);

        go8(OP_LOAD, 3'd0, 8'h80);
        go8(OP_ASR, 3'd7, 8'h00);
        wait8(lat, bz);
        check("asr7_q", 32'(if8.q), 32'hFF);
        check("asr7_so", 32'(if8.shift_out), 32'h0);

        go8(OP_LOAD, 3'd0, 8'hB5);
        n0 = n_done8;
        go8(OP_ROR, 3'd4, 8'h00);
        @(negedge clk);
        check("ror4_busy2", 32'(if8.busy), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_q", 32'(if8.q), 32'h00);
        check("abort_busy", 32'(if8.busy), 32'h0);
        check("abort_done", 32'(if8.done), 32'h0);
        check("abort_so", 32'(if8.shift_out), 32'h0);
        repeat (4) @(negedge clk);
        check("abort_no_done", 32'(n_done8 - n0), 32'd0);
        go8(OP_LOAD, 3'd0, 8'h3C);
        check("relo_q", 32'(if8.q), 32'h3C);
        check("relo_done", 32'(if8.done), 32'h1);

        go8(OP_LSR, 3'd1, 8'h00);
        check("b2b_q", 32'(if8.q), 32'h1E);
        check("b2b_done", 32'(if8.done), 32'h1);
        check("b2b_so", 32'(if8.shift_out), 32'h0);

        go8(OP_NOP, 3'd3, 8'hAA);
        check("nop_q", 32'(if8.q), 32'h1E);
        check("nop_done", 32'(if8.done), 32'h1);
        go8(3'b111, 3'd2, 8'hAA);
        check("rsv_q", 32'(if8.q), 32'h1E);
        check("rsv_done", 32'(if8.done), 32'h1);
        check("rsv_busy", 32'(if8.busy), 32'h0);

        go16(OP_LOAD, 4'd0, 16'h8001);
        check("w16_load", 32'(if16.q), 32'h8001);
        go16(OP_ROR, 4'd15, 16'h0000);
        wait16(lat, bz);
        check("w16_ror_lat", 32'(lat), 32'd15);
        check("w16_ror_busy", 32'(bz), 32'd14);
        check("w16_ror_q", 32'(if16.q), 32'h0003);
        check("w16_ror_so", 32'(if16.shift_out), 32'h0);
        go16(OP_LSL, 4'd0, 16'hFFFF);
        check("w16_amt0_done", 32'(if16.done), 32'h1);
        check("w16_amt0_q", 32'(if16.q), 32'h0003);
        check("w16_amt0_busy", 32'(if16.busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shifter_seq_n.md
Name: shifter_seq_n

Overview:
- Parametrised, multi-cycle shift register unit; successor to the 8-bit mux-based combinational shifter.
- Loads a WIDTH-bit word and applies logical, arithmetic or rotate shifts by a run-time amount, one bit position per clock.
- Uses a start/busy/done handshake. Sits between datapath register files and the ALU result mux.

Parameters:
- WIDTH, 8, data width in bits; must be ≥ 2.
- AW, $clog2(WIDTH), width of the shift-amount field. Derived localparam, not overridden by instantiators.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request strobe; sampled only when not busy
- op  input  3  operation code, see Behaviour
- amt  input  AW  shift amount, 0..WIDTH-1
- d_in  input  WIDTH  load data
- q  output  WIDTH  shift register contents (registered)
- shift_out  output  1  last bit shifted or rotated out (registered)
- busy  output  1  high while a multi-step shift is in progress
- done  output  1  one-cycle pulse when an operation completes

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values: q=0, shift_out=0, busy=0, done=0, FSM=IDLE, cnt=0.
- Op codes:
  - 000 NOP
  - 001 LOAD
  - 010 LSL (0 fill)
  - 011 LSR (0 fill)
  - 100 ASR (MSB replicated)
  - 101 ROL
  - 110 ROR
  - 111 reserved, treated as NOP
- FSM states: IDLE, SHIFT.
- IDLE, start=0: hold all registers; done=0.
- IDLE, start=1, NOP/reserved: q unchanged; done=1 for one cycle.
- IDLE, start=1, LOAD: q<=d_in, shift_out unchanged, done=1 on the same edge (latency 1).
- IDLE, start=1, shift op, amt=0: q and shift_out unchanged; done=1 next cycle.
- IDLE, start=1, shift op, amt=k≥1: on the accepting edge, op is latched, q<=one-step shift of q, shift_out<=bit leaving, cnt<=k-1.
  - k=1: done=1, stay in IDLE.
  - k>1: go to SHIFT with busy=1.
- SHIFT, each edge: one step applied with the latched op, cnt decrements.
  - On the edge where cnt==1: done<=1, busy<=0, go to IDLE.
- Total latency for amt=k: k edges after the accepting edge inclusive. busy is high for k-1 cycles. done pulses exactly once per accepted start.
- start while busy=1: ignored, no queuing. op, amt and d_in are don't-care during SHIFT.
- start on the same cycle done is high: accepted, since the FSM is IDLE. Back-to-back operations are legal.
- ROL/ROR by k equals the result of k single rotates. No special case at k=WIDTH-1.
- shift_out for ROL/ROR is the bit that wrapped.
- ASR of a negative value converges to all ones; LSR/LSL converge to zeros for large k.
- reset mid-SHIFT: takes priority over everything. Next cycle q=0, busy=0, done=0, IDLE. No done pulse for the aborted operation.
- amt ≥ WIDTH is unreachable when WIDTH is a power of 2. Otherwise the shift runs amt steps with no saturation.

Decomposition:
- Package shifter_pkg:
  - op code localparams OP_NOP, OP_LOAD, OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR
  - FSM state encodings ST_IDLE, ST_SHIFT
- Sub-module shift1_unit, combinational and parametrised by WIDTH:
  - inputs: q, op
  - outputs: next q, bit-out
  - built as a per-bit 4:1 selection (hold/left/right/fill) so the existing mux cell style is reused.
- Top level holds the FSM, the counter, the op latch and the output registers.

Test Plan:
- Reset then LOAD d_in=8'hB5 -> q=8'hB5 and done=1 one cycle after the start edge; busy stays 0.
- q=8'hB5, ROL amt=3 -> busy high 2 cycles, then done pulse, q=8'hAD, shift_out=1.
- q=8'hB5, ASR amt=2 -> q=8'hED after 2 edges, shift_out=0; LSL amt=1 from 8'hB5 -> q=8'h6A, shift_out=1, done after 1 edge, busy never high.
- LOAD 8'h96 then LSR amt=7 -> q=8'h01, shift_out=0; a start pulsed during busy with op=LOAD, d_in=8'hFF is ignored (q still 8'h01, one done only).
- ROR amt=4 on 8'hB5, reset asserted on the 2nd busy cycle -> q=0, busy=0, no done; next LOAD 8'h3C succeeds normally.
- WIDTH=16 instance, LOAD 16'h8001 then ROR amt=15 -> q=16'h0003; shift op with amt=0 -> done next cycle, q unchanged.
